sdram_cmd_sequencer: RTL
========================

SDRAM_CMD_SEQUENCER -- requirements
Module: sdram_cmd_sequencer

Interface
REQ-001 The block SHALL have one clock, pclk; reset, preset, is asynchronous and active-high.
REQ-002 The block SHALL sit directly downstream of the APB-side dram_controller front-end: it accepts word requests and drives SDRAM pins.
REQ-003 The block SHALL have the following parameters (name, default, meaning):
- DATA_W, 16: SDRAM data width.
- T_RCD, 2: cycles from ACTIVE to READ/WRITE.
- T_RP, 2: cycles from PRECHARGE to the next command.
- T_WR, 2: cycles from WRITE to PRECHARGE.
- T_RFC, 7: cycles from AUTO REFRESH to the next command.
- CAS_LAT, 2: read latency in cycles, 2 or 3.
- REF_INTERVAL, 780: cycles between refresh requests.
- INIT_WAIT, 20000: power-up NOP cycles.
REQ-004 The block SHALL have the following ports (name, direction, width, meaning):
- pclk, in, 1: clock.
- preset, in, 1: async active-high reset.
- req_valid, in, 1: request present.
- req_ready, out, 1: request accepted when req_valid and req_ready are both high.
- req_write, in, 1: 1 = write, 0 = read.
- req_addr, in, 24: {bank[23:22], row[21:9], col[8:0]}.
- req_wdata, in, DATA_W: write data.
- rsp_valid, out, 1: one-cycle read-data strobe.
- rsp_rdata, out, DATA_W: read data.
- init_done, out, 1: initialisation complete.
- sd_cke, out, 1: SDRAM clock enable.
- sd_cmd, out, 4: {cs_n, ras_n, cas_n, we_n}.
- sd_ba, out, 2: bank address.
- sd_addr, out, 13: row/column/mode address.
- sd_dq_out, out, DATA_W: write data to the pads.
- sd_dq_oe, out, 1: DQ output enable.
- sd_dq_in, in, DATA_W: read data from the pads.

Function
REQ-005 All outputs SHALL be registered; every command SHALL be driven for exactly one cycle, and sd_cmd SHALL be NOP (0111) otherwise.
REQ-006 Command encodings (sd_cmd):
- ACTIVE = 0011.
- READ = 0101.
- WRITE = 0100.
- PRECHARGE = 0010, with sd_addr[10]=1 (all banks).
- AUTO REFRESH = 0001.
- LOAD MODE = 0000.
REQ-007 State machine states: INIT_WAIT, INIT_PRE, INIT_REF1, INIT_REF2, INIT_MRS, IDLE, ACTIVATE, RW, RD_WAIT, PRECHARGE, REFRESH. A shared down-counter SHALL enforce every timing wait.
REQ-008 Initialisation sequence:
- sd_cke=1 from the first cycle after reset deassertion.
- INIT_WAIT cycles of NOP.
- PRECHARGE all, then T_RP.
- AUTO REFRESH, then T_RFC; AUTO REFRESH, then T_RFC.
- LOAD MODE with sd_addr = {3'b0, 1'b0, 2'b0, CAS_LAT[2:0], 1'b0, 3'b000}, sd_ba=0, then 2 cycles.
- init_done=1 and state IDLE.
REQ-009 req_ready SHALL be 1 only in IDLE with init_done=1 and the registered ref_pending=0. Accepted addr, data and direction SHALL be latched.
REQ-010 The block SHALL use a closed-page policy. Taking the handshake edge as cycle 0:
- ACTIVE (row, bank) at cycle 1.
- READ/WRITE (sd_addr = {4'b0, col}) at cycle 1+T_RCD.
REQ-011 Write: sd_dq_oe=1 and sd_dq_out=wdata only in the WRITE cycle; PRECHARGE at WRITE+T_WR.
REQ-012 Read:
- sd_dq_in is sampled at the end of cycle READ+CAS_LAT.
- rsp_valid=1 with rsp_rdata at cycle READ+CAS_LAT+1, and PRECHARGE is driven in that same cycle.
- rsp_rdata SHALL hold its value until the next read.
REQ-013 After PRECHARGE at cycle P, req_ready SHALL rise at cycle P+T_RP.
REQ-014 Refresh counter behaviour:
- The refresh counter starts when init_done rises.
- On reaching REF_INTERVAL it wraps to 0 and sets ref_pending on the next edge.
- A further expiry while ref_pending=1 SHALL NOT queue a second refresh.
REQ-015 Refresh servicing:
- In IDLE, ref_pending has priority over requests: AUTO REFRESH is issued, ref_pending clears, and the block waits T_RFC then returns to IDLE.
- An in-flight access SHALL complete before the refresh is issued.
REQ-016 If a request is accepted in the same cycle the counter expires, the access SHALL run first and the refresh SHALL follow immediately after T_RP.
REQ-017 While req_ready=0, req_valid SHALL be ignored; there is no request buffering.

Reset
REQ-018 On preset=1, asynchronously and regardless of state, the block SHALL return to INIT_WAIT with these output values:
- sd_cke=0, sd_cmd=1111, sd_ba=0, sd_addr=0.
- sd_dq_out=0, sd_dq_oe=0.
- req_ready=0, rsp_valid=0, rsp_rdata=0, init_done=0.
- refresh counter=0, ref_pending=0.
REQ-019 Reset asserted mid-access SHALL abort the access with no rsp_valid, and full initialisation SHALL repeat after deassertion.

Verification (INIT_WAIT=100, other parameters default)
REQ-020 Initialisation: release reset and check 100 NOP cycles, then PRECHARGE(addr[10]=1), REFRESH, REFRESH, and LOAD MODE with sd_addr=0x020; init_done rises 2 cycles after LOAD MODE.
REQ-021 Write: addr=0x4A_0213, data=0xBEEF accepted at cycle 0 -> ACTIVE ba=1, row=0x0501 at cycle 1; WRITE col=0x013 with dq_oe=1, dq=0xBEEF at cycle 3; PRECHARGE at cycle 5; req_ready=1 at cycle 7.
REQ-022 Read: same address, sd_dq_in=0x1234 during cycle 5 -> READ at cycle 3; rsp_valid=1, rsp_rdata=0x1234 at cycle 6; PRECHARGE at cycle 6; req_ready=1 at cycle 8.
REQ-023 Refresh: idle for 780 cycles after init_done -> exactly one AUTO REFRESH; req_ready=0 from ref_pending until T_RFC has elapsed; a request held valid is accepted afterwards.
REQ-024 Collision: request accepted on the refresh-expiry cycle -> the access completes, then AUTO REFRESH at P+T_RP, then req_ready returns.
REQ-025 Reset mid-read: assert preset between READ and capture -> outputs at reset values immediately, no rsp_valid, and the init sequence repeats.

Source files
------------

// File: rtl/sdram_cmd_sequencer.sv
// sdram_cmd_sequencer: SDRAM init, refresh and closed-page access sequencer; req_*/rsp_* word port in, registered sd_* pin drive out
module sdram_cmd_sequencer #(
  parameter int DATA_W = 16,
  parameter int T_RCD = 2,
  parameter int T_RP = 2,
  parameter int T_WR = 2,
  parameter int T_RFC = 7,
  parameter int CAS_LAT = 2,
  parameter int REF_INTERVAL = 780,
  parameter int INIT_WAIT = 20000
) (
  input  logic pclk,
  input  logic preset,
  input  logic req_valid,
  output logic req_ready,
  input  logic req_write,
  input  logic [23:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic init_done,
  output logic sd_cke,
  output logic [3:0] sd_cmd,
  output logic [1:0] sd_ba,
  output logic [12:0] sd_addr,
  output logic [DATA_W-1:0] sd_dq_out,
  output logic sd_dq_oe,
  input  logic [DATA_W-1:0] sd_dq_in
);
  localparam logic [3:0] NOP = 4'b0111, ACT = 4'b0011, RD = 4'b0101, WR = 4'b0100;
  localparam logic [3:0] PRE = 4'b0010, REF = 4'b0001, MRS = 4'b0000;
  localparam int CW = 16;
  localparam int RW = $clog2(REF_INTERVAL);
  typedef enum logic [3:0] {
    ST_INIT_WAIT, ST_INIT_PRE, ST_INIT_REF1, ST_INIT_REF2, ST_INIT_MRS,
    ST_IDLE, ST_ACTIVATE, ST_RW, ST_RD_WAIT, ST_PRECHARGE, ST_REFRESH
  } state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [RW-1:0] ref_cnt;
  logic ref_pending, wr_l, expire;
  logic [23:0] addr_l;
  logic [DATA_W-1:0] wdata_l;
  assign expire = init_done && (ref_cnt == RW'(REF_INTERVAL - 1));
  always_ff @(posedge pclk or posedge preset)
    if (preset) begin
      state <= ST_INIT_WAIT;
      cnt <= CW'(INIT_WAIT);
      ref_cnt <= '0;
      ref_pending <= 1'b0;
      wr_l <= 1'b0;
      addr_l <= '0;
      wdata_l <= '0;
      sd_cke <= 1'b0;
      sd_cmd <= 4'b1111;
      sd_ba <= '0;
      sd_addr <= '0;
      sd_dq_out <= '0;
      sd_dq_oe <= 1'b0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      init_done <= 1'b0;
    end else begin
      sd_cke <= 1'b1;
      sd_cmd <= NOP;
      sd_dq_out <= '0;
      sd_dq_oe <= 1'b0;
      rsp_valid <= 1'b0;
      req_ready <= 1'b0;
      if (cnt != '0) cnt <= cnt - CW'(1);
      ref_cnt <= (!init_done || expire) ? '0 : ref_cnt + RW'(1);
      if (expire) ref_pending <= 1'b1;
      case (state)
        ST_INIT_WAIT: if (cnt == '0) begin
          sd_cmd <= PRE;
          sd_addr <= 13'h400;
          cnt <= CW'(T_RP - 1);
          state <= ST_INIT_PRE;
        end
        ST_INIT_PRE: if (cnt == '0) begin
          sd_cmd <= REF;
          cnt <= CW'(T_RFC - 1);
          state <= ST_INIT_REF1;
        end
        ST_INIT_REF1: if (cnt == '0) begin
          sd_cmd <= REF;
          cnt <= CW'(T_RFC - 1);
          state <= ST_INIT_REF2;
        end
        ST_INIT_REF2: if (cnt == '0) begin
          sd_cmd <= MRS;
          sd_ba <= '0;
          sd_addr <= {3'b0, 1'b0, 2'b0, 3'(CAS_LAT), 1'b0, 3'b000};
          cnt <= CW'(1);
          state <= ST_INIT_MRS;
        end
        ST_INIT_MRS: if (cnt == '0) begin
          init_done <= 1'b1;
          req_ready <= 1'b1;
          state <= ST_IDLE;
        end
        ST_IDLE, ST_PRECHARGE, ST_REFRESH: if (cnt == '0) begin
          if (ref_pending) begin
            sd_cmd <= REF;
            ref_pending <= expire;
            cnt <= CW'(T_RFC - 1);
            state <= ST_REFRESH;
          end else if (req_valid && req_ready) begin
            wr_l <= req_write;
            addr_l <= req_addr;
            wdata_l <= req_wdata;
            state <= ST_ACTIVATE;
          end else begin
            req_ready <= !expire;
            state <= ST_IDLE;
          end
        end
        ST_ACTIVATE: begin
          sd_cmd <= ACT;
          sd_ba <= addr_l[23:22];
          sd_addr <= addr_l[21:9];
          cnt <= CW'(T_RCD - 1);
          state <= ST_RW;
        end
        ST_RW: if (cnt == '0) begin
          sd_cmd <= wr_l ? WR : RD;
          sd_ba <= addr_l[23:22];
          sd_addr <= {4'b0, addr_l[8:0]};
          sd_dq_oe <= wr_l;
          if (wr_l) sd_dq_out <= wdata_l;
          cnt <= wr_l ? CW'(T_WR - 1) : CW'(CAS_LAT);
          state <= ST_RD_WAIT;
        end
        ST_RD_WAIT: if (cnt == '0) begin
          rsp_valid <= !wr_l;
          if (!wr_l) rsp_rdata <= sd_dq_in;
          sd_cmd <= PRE;
          sd_addr <= 13'h400;
          cnt <= CW'(T_RP - 1);
          state <= ST_PRECHARGE;
        end
        default: state <= ST_INIT_WAIT;
      endcase
    end
endmodule
